// File: rtl/cu_multicycle_seq.sv
// cu_multicycle_seq: multi-cycle control sequencer (FETCH/EXEC/MEM/TRAP) driving the datapath control word.
// Ports: clock, reset (sync, high) | IR, status {N,Z,C,V}, mem_ready | controlWord, k_mux, state, trap, trap_cause.
module cu_multicycle_seq #(
  parameter int unsigned WAIT_MAX        = 15,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned CW_W            = 36
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     IR,
  input  logic [3:0]      status,
  input  logic            mem_ready,
  output logic [CW_W-1:0] controlWord,
  output logic [2:0]      k_mux,
  output logic [2:0]      state,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_TRAP  = 3'd3
  } state_e;

  typedef struct packed {
    logic [4:0] fs;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       w_reg;
    logic       c0;
    logic [1:0] mem_cs;
    logic       b_sel;
    logic       mem_write_en;
    logic       ir_load;
    logic       status_load;
    logic [1:0] size;
    logic       add_tri_sel;
    logic [1:0] data_tri_sel;
    logic       pc_sel;
    logic [1:0] pc_fs;
  } cw_t;

  localparam logic [7:0] WMAX  = 8'(WAIT_MAX);
  localparam logic [2:0] C_ALU = 3'd0;
  localparam logic [2:0] C_LD  = 3'd1;
  localparam logic [2:0] C_ST  = 3'd2;
  localparam logic [2:0] C_B   = 3'd3;
  localparam logic [2:0] C_CB  = 3'd4;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] cause_q, cause_d;
  cw_t        cw;
  logic [2:0] kmux;
  logic       taken;
  logic [2:0] cls;
  logic       n_f, z_f, c_f, v_f;
  logic       unused_ir;

  assign cls = IR[2:0];
  assign {n_f, z_f, c_f, v_f} = status;
  assign unused_ir = ^{IR[21], IR[18:16], IR[7:4]};

  always_comb begin
    taken = 1'b0;
    unique case (IR[25:22])
      4'd0:    taken = z_f;
      4'd1:    taken = !z_f;
      4'd2:    taken = c_f;
      4'd3:    taken = !c_f;
      4'd4:    taken = n_f;
      4'd5:    taken = !n_f;
      4'd6:    taken = v_f;
      4'd7:    taken = !v_f;
      4'd8:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cause_d = cause_q;
    cw      = '0;
    kmux    = 3'b000;
    unique case (state_q)
      S_FETCH: begin
        cw.mem_cs      = 2'b10;
        cw.add_tri_sel = 1'b1;
        if (mem_ready) begin
          cw.ir_load = 1'b1;
          cw.pc_fs   = 2'b01;
          wait_d     = '0;
          state_d    = S_EXEC;
        end else if (wait_q == WMAX) begin
          cause_d = 2'b10;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (1'b1)
          (cls == C_ALU): begin
            unique case ({IR[10:9], IR[3]})
              3'b000, 3'b001: cw.fs = 5'b01000;
              3'b010, 3'b011: cw.fs = 5'b01001;
              3'b100, 3'b101: cw.fs = 5'b00000;
              3'b110:         cw.fs = 5'b00100;
              default:        cw.fs = 5'b01100;
            endcase
            cw.w_reg       = 1'b1;
            cw.c0          = IR[9];
            cw.status_load = (IR[8] & IR[3]) | (IR[9] & IR[8]);
          end
          (cls == C_LD), (cls == C_ST): begin
            cw.fs    = 5'b01000;
            cw.b_sel = 1'b1;
            cw.size  = IR[20:19];
            kmux     = 3'b001;
            state_d  = S_MEM;
          end
          (cls == C_B), (cls == C_CB && taken): begin
            cw.pc_sel = 1'b1;
            cw.pc_fs  = 2'b10;
            kmux      = 3'b010;
          end
          (cls == C_CB && !taken): begin
            cw.pc_fs = 2'b00;
          end
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              cause_d = 2'b01;
              state_d = S_TRAP;
            end
          end
        endcase
        // register fields only mean something for a decodable class
        if (cls <= C_CB) begin
          cw.sa = IR[26:22];
          cw.sb = IR[15:11];
          cw.da = IR[31:27];
        end
      end
      S_MEM: begin
        cw.sa           = IR[26:22];
        cw.sb           = IR[15:11];
        cw.da           = IR[31:27];
        cw.mem_cs       = 2'b11;
        cw.size         = IR[20:19];
        cw.mem_write_en = (cls == C_ST);
        if (mem_ready) begin
          if (cls == C_LD) begin
            cw.w_reg        = 1'b1;
            cw.data_tri_sel = 2'b01;
          end
          wait_d  = '0;
          state_d = S_FETCH;
        end else if (wait_q == WMAX) begin
          cause_d = 2'b11;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // outputs are forced quiet while reset is held
    if (reset) begin
      cw   = '0;
      kmux = 3'b000;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  assign controlWord = cw;
  assign k_mux       = kmux;
  assign state       = state_q;
  assign trap        = (state_q == S_TRAP);
  assign trap_cause  = cause_q;

endmodule
